// File: rtl/srl_probe_pkg.sv
// srl_probe_pkg: state encoding and result status codes shared by the delay-line probe
package srl_probe_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_STUCK   = 2'd2;
  localparam logic [1:0] ST_WIDTH   = 2'd3;
endpackage

// File: rtl/srl_delay_probe.sv
// srl_delay_probe: flushes a delay line, launches one marker on od, measures its latency on ioq (iclk/ireset/istart/ioq in; od/obusy/odone/olatency/ostatus out)
module srl_delay_probe
  import srl_probe_pkg::*;
#(
  parameter int MAX_DELAY = 256,
  parameter int CNT_W     = 9
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             istart,
  input  logic             ioq,
  output logic             od,
  output logic             obusy,
  output logic             odone,
  output logic [CNT_W-1:0] olatency,
  output logic [1:0]       ostatus
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DELAY);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max, w_inc;
  assign w_at_max = r_cnt == MAX_CNT;
  assign w_inc    = (r_state == S_FLUSH || r_state == S_WAIT) && w_next == r_state;
  assign od       = r_state == S_LAUNCH;
  assign obusy    = r_state inside {S_FLUSH, S_LAUNCH, S_WAIT, S_CHECK};
  assign odone    = r_state == S_DONE;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = istart ? S_FLUSH : S_IDLE;
      S_FLUSH:  w_next = !w_at_max ? S_FLUSH : ioq ? S_DONE : S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   w_next = ioq ? S_CHECK : w_at_max ? S_DONE : S_WAIT;
      S_CHECK:  w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      olatency <= '0;
      ostatus  <= ST_OK;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_inc ? r_cnt + 1'b1 : r_state == S_LAUNCH ? CNT_W'(1) : '0;
      if (r_state == S_FLUSH && w_at_max && ioq) begin
        ostatus  <= ST_STUCK;
        olatency <= '0;
      end else if (r_state == S_WAIT && ioq) begin
        olatency <= r_cnt;
      end else if (r_state == S_WAIT && w_at_max) begin
        ostatus  <= ST_TIMEOUT;
        olatency <= MAX_CNT;
      end else if (r_state == S_CHECK) begin
        ostatus  <= ioq ? ST_WIDTH : ST_OK;
      end
    end
  end
endmodule

// File: tb/tb_srl_delay_probe.sv
// tb_srl_delay_probe: drives the probe against a behavioural delay line and checks results against a rule-based model
module tb_srl_delay_probe;
  localparam int MAXD = 256;
  localparam int CW   = 9;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, dl_rst = 1'b1;
  logic          ioq, od, busy, done;
  logic [CW-1:0] lat;
  logic [1:0]    st;
  logic [MAXD:0] sr;
  int            mode = 0, n = 128;
  int            checks = 0, failures = 0;
  srl_delay_probe #(.MAX_DELAY(MAXD), .CNT_W(CW)) dut (
    .iclk(clk), .ireset(rst), .istart(start), .ioq(ioq),
    .od(od), .obusy(busy), .odone(done), .olatency(lat), .ostatus(st)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) sr <= dl_rst ? '1 : {sr[MAXD-1:0], od};
  assign ioq = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 :
               mode == 3 ? (sr[9'(n-1)] | sr[9'(n)]) : sr[9'(n-1)];
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic void model(input int m, input int nn, output int el, output int es,
                                output int eb, output int ep);
    if (m == 1) begin
      el = MAXD; es = 1; eb = (MAXD + 1) + 1 + MAXD; ep = 1;
    end else if (m == 2) begin
      el = 0; es = 2; eb = MAXD + 1; ep = 0;
    end else begin
      el = nn; es = (m == 3) ? 3 : 0; eb = (MAXD + 1) + 1 + nn + 1; ep = 1;
    end
  endfunction
  task automatic measure(input int m, input int nn, input bit poke);
    int el, es, eb, ep;
    int bcnt = 0, ocnt = 0, cyc = 0;
    model(m, nn, el, es, eb, ep);
    mode = m;
    n = nn;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!done && cyc < 1000) begin
      if (busy) bcnt++;
      if (od) ocnt++;
      if (poke) start = 1'($urandom % 2);
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("done_seen m%0d n%0d", m, nn), int'(done), 1);
    chk($sformatf("latency m%0d n%0d", m, nn), int'(lat), el);
    chk($sformatf("status m%0d n%0d", m, nn), int'(st), es);
    chk($sformatf("busy_cycles m%0d n%0d", m, nn), bcnt, eb);
    chk($sformatf("od_pulses m%0d n%0d", m, nn), ocnt, ep);
    chk("busy_in_done", int'(busy), 0);
    start = poke;
    @(negedge clk) start = 1'b0;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    @(negedge clk);
    chk("no_extra_run", int'(busy), 0);
  endtask
  initial begin
    int el, es, eb, ep, dn, gap, last;
    repeat (3) @(negedge clk);
    chk("rst_od", int'(od), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_lat", int'(lat), 0);
    chk("rst_status", int'(st), 0);
    rst = 1'b0;
    dl_rst = 1'b0;
    measure(0, 128, 0);
    measure(0, 1, 1);
    measure(0, MAXD, 1);
    measure(1, 64, 0);
    measure(2, 64, 0);
    measure(3, 40, 0);
    mode = 3;
    n = 40;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat ((MAXD + 1) + 1 + 10) @(negedge clk);
    chk("mid_wait_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midrst_od", int'(od), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_lat", int'(lat), 0);
    chk("midrst_status", int'(st), 0);
    repeat (60) @(negedge clk);
    chk("midrst_stays_idle", int'(busy), 0);
    for (int i = 0; i < 6; i++)
      measure(int'($urandom_range(0, 3)), int'($urandom_range(1, MAXD)), 1'($urandom % 2));
    model(0, 16, el, es, eb, ep);
    mode = 0;
    n = 16;
    dn = 0;
    last = 0;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c < 2000 && dn < 3; c++) begin
      @(negedge clk);
      if (done) begin
        chk($sformatf("b2b_lat_%0d", dn), int'(lat), el);
        chk($sformatf("b2b_status_%0d", dn), int'(st), es);
        if (dn > 0) begin
          gap = c - last;
          chk($sformatf("b2b_period_%0d", dn), gap, eb + 2);
        end
        last = c;
        dn++;
      end
    end
    chk("b2b_runs", dn, 3);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
